// File: rtl/led_counter_pkg.sv
// Shared command opcodes and FSM state encoding for the LED counter sequencer.
package led_counter_pkg;

    // Command opcodes carried on cmd_op
    localparam logic [1:0] OP_STOP     = 2'd0;
    localparam logic [1:0] OP_RUN_UP   = 2'd1;
    localparam logic [1:0] OP_RUN_DOWN = 2'd2;
    localparam logic [1:0] OP_LOAD     = 2'd3;

    // Sequencer state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;
    localparam logic [1:0] ST_LOAD = 2'd3;

endpackage

// File: rtl/led_counter_sequencer_tick_prescaler.sv
// Step prescaler: counts 0..PRESCALE-1 while run is high and pulses tick on the last count.
// Any clear or idle cycle returns the count to zero.
module tick_prescaler #(
    parameter int unsigned PRESCALE = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick on the final count of each step period
    assign tick = run && (cnt_q == LAST);

    // Next count: restart on clear, idle or tick
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || !run || tick) begin
            cnt_d = '0;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_counter_sequencer.sv
// LED counter sequencer: command-driven up/down/load counter stepping at a prescaled rate.
// Optional macro LED_COUNTER_SEQUENCER_BOUNCE_EN makes the count reverse at the terminal
// values instead of wrapping modulo 2^CNT_WIDTH.
module led_counter_sequencer #(
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned PRESCALE  = 25000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [CNT_WIDTH-1:0] cmd_data,
    output logic [CNT_WIDTH-1:0] led,
    output logic                 busy,
    output logic                 wrap
);

    import led_counter_pkg::*;

    localparam logic [CNT_WIDTH-1:0] ALL_ONES = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

    logic [1:0]           state_q, state_d;
    logic [1:0]           ret_q, ret_d;
    logic [CNT_WIDTH-1:0] led_q, led_d;
    logic [CNT_WIDTH-1:0] load_q, load_d;
    logic                 wrap_q, wrap_d;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;
    logic                 accept;
    logic                 run;
    logic                 tick;

    assign accept = cmd_valid && ready_q;
    assign run    = (state_q == ST_UP) || (state_q == ST_DOWN);

    // Prescaler runs only in UP/DOWN and restarts on every accepted command
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .clear (accept),
        .tick  (tick)
    );

    // Next-state, count and wrap decode; an accepted command beats a coincident tick
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        led_d   = led_q;
        load_d  = load_q;
        wrap_d  = 1'b0;
        if (state_q == ST_LOAD) begin
            led_d   = load_q;
            state_d = ret_q;
        end else if (accept) begin
            case (cmd_op)
                OP_STOP:     state_d = ST_IDLE;
                OP_RUN_UP:   state_d = ST_UP;
                OP_RUN_DOWN: state_d = ST_DOWN;
                default: begin
                    ret_d   = state_q;
                    load_d  = cmd_data;
                    state_d = ST_LOAD;
                end
            endcase
        end else if (tick && state_q == ST_UP) begin
            wrap_d = (led_q == ALL_ONES);
`ifdef LED_COUNTER_SEQUENCER_BOUNCE_EN
            if (led_q == ALL_ONES) begin
                led_d   = ALL_ONES - ONE;
                state_d = ST_DOWN;
            end else begin
                led_d = led_q + ONE;
            end
`else
            led_d = led_q + ONE;
`endif
        end else if (tick && state_q == ST_DOWN) begin
            wrap_d = (led_q == '0);
`ifdef LED_COUNTER_SEQUENCER_BOUNCE_EN
            if (led_q == '0) begin
                led_d   = ONE;
                state_d = ST_UP;
            end else begin
                led_d = led_q - ONE;
            end
`else
            led_d = led_q - ONE;
`endif
        end
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d != ST_LOAD);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ret_q   <= ST_IDLE;
            led_q   <= '0;
            load_q  <= '0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            led_q   <= led_d;
            load_q  <= load_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign led       = led_q;
    assign wrap      = wrap_q;
    assign busy      = busy_q;
    assign cmd_ready = ready_q;

endmodule

// File: tb/tb_led_counter_sequencer.sv
// Self-checking bench for led_counter_sequencer (PRESCALE=4, CNT_WIDTH=8): directed
// test-plan steps followed by random commands, checked every cycle against a behavioural model.
module tb_led_counter_sequencer;

    localparam int PS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] led;
    logic       busy;
    logic       wrap;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: mode 0=idle 1=up 2=down 3=load
    int m_mode = 0;
    int m_ret  = 0;
    int m_led  = 0;
    int m_data = 0;
    int m_age  = 0;
    int m_wrap = 0;

    led_counter_sequencer #(
        .CNT_WIDTH (8),
        .PRESCALE  (PS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .led       (led),
        .busy      (busy),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge given the inputs presented at that edge
    task automatic model_edge(input bit r, input bit v, input int op, input int d);
        m_wrap = 0;
        if (r) begin
            m_mode = 0; m_ret = 0; m_led = 0; m_age = 0;
        end else if (m_mode == 3) begin
            m_led  = m_data;
            m_mode = m_ret;
            m_age  = 0;
        end else if (v) begin
            m_age = 0;
            if (op == 0) m_mode = 0;
            else if (op == 1) m_mode = 1;
            else if (op == 2) m_mode = 2;
            else begin
                m_ret = m_mode; m_data = d; m_mode = 3;
            end
        end else if (m_mode == 1 || m_mode == 2) begin
            m_age++;
            if (m_age == PS) begin
                m_age = 0;
`ifdef LED_COUNTER_SEQUENCER_BOUNCE_EN
                if (m_mode == 1 && m_led == 255) begin
                    m_led = 254; m_mode = 2; m_wrap = 1;
                end else if (m_mode == 2 && m_led == 0) begin
                    m_led = 1; m_mode = 1; m_wrap = 1;
                end else begin
                    m_led = (m_mode == 1) ? m_led + 1 : m_led - 1;
                end
`else
                if (m_mode == 1) begin
                    m_wrap = (m_led == 255) ? 1 : 0;
                    m_led  = (m_led + 1) % 256;
                end else begin
                    m_wrap = (m_led == 0) ? 1 : 0;
                    m_led  = (m_led + 255) % 256;
                end
`endif
            end
        end
    endtask

    // One clock: drive inputs, step model, sample after the edge and compare everything
    task automatic cyc(input bit r, input bit v, input int op, input int d);
        rst       = r;
        cmd_valid = v;
        cmd_op    = 2'(op);
        cmd_data  = 8'(d);
        model_edge(r, v && (m_mode != 3), op, d);
        @(posedge clk);
        #1;
        check("led", int'(led), m_led);
        check("wrap", int'(wrap), m_wrap);
        check("busy", int'(busy), (m_mode != 0) ? 1 : 0);
        check("cmd_ready", int'(cmd_ready), (m_mode != 3) ? 1 : 0);
        rst       = 1'b0;
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        int wraps;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 8'd0;

        // Reset then 20 quiet cycles
        cyc(1'b1, 1'b0, 0, 0);
        cyc(1'b1, 1'b0, 0, 0);
        check("reset_led", int'(led), 0);
        check("reset_ready", int'(cmd_ready), 1);
        idle(20);

        // RUN_UP, steps at +4/+8/+12, STOP at +13, hold 20 cycles
        cyc(1'b0, 1'b1, 1, 0);
        idle(4);  check("up_step1", int'(led), 1);
        idle(4);  check("up_step2", int'(led), 2);
        idle(4);  check("up_step3", int'(led), 3);
        cyc(1'b0, 1'b1, 0, 0);
        idle(20); check("stop_hold", int'(led), 3);
        check("stop_busy", int'(busy), 0);

        // LOAD 0xFE while running up, then terminal crossing
        cyc(1'b0, 1'b1, 1, 0);
        cyc(1'b0, 1'b1, 3, 8'hFE);
        check("load_ready_low", int'(cmd_ready), 0);
        cyc(1'b0, 1'b1, 2, 0);   // ignored: not ready during LOAD
        check("load_applied", int'(led), 8'hFE);
        check("load_ret_busy", int'(busy), 1);
        wraps = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 0, 0);
            wraps += int'(wrap);
        end
`ifdef LED_COUNTER_SEQUENCER_BOUNCE_EN
        check("bounce_led", int'(led), 8'hFE);
`else
        check("wrap_led", int'(led), 8'h00);
`endif
        check("wrap_count", wraps, 1);

        // RUN_DOWN from 0
        cyc(1'b0, 1'b1, 0, 0);
        cyc(1'b0, 1'b1, 3, 0);
        idle(1);
        cyc(1'b0, 1'b1, 2, 0);
        idle(4);
`ifdef LED_COUNTER_SEQUENCER_BOUNCE_EN
        check("down_bounce_led", int'(led), 8'h01);
`else
        check("down_wrap_led", int'(led), 8'hFF);
`endif
        check("down_wrap", int'(wrap), 1);

        // RUN_UP re-issued on the tick edge suppresses that step
        cyc(1'b0, 1'b1, 0, 0);
        cyc(1'b0, 1'b1, 3, 8'h10);
        idle(1);
        cyc(1'b0, 1'b1, 1, 0);
        idle(3);
        cyc(1'b0, 1'b1, 1, 0);
        check("reissue_nostep", int'(led), 8'h10);
        idle(3);  check("reissue_wait", int'(led), 8'h10);
        idle(1);  check("reissue_step", int'(led), 8'h11);

        // Reset during the LOAD cycle discards the load
        cyc(1'b0, 1'b1, 3, 8'h55);
        cyc(1'b1, 1'b0, 0, 0);
        check("rst_load_led", int'(led), 0);
        idle(3);
        check("rst_load_after", int'(led), 0);

        // Random commands with occasional reset
        for (int i = 0; i < 600; i++) begin
            bit r;
            bit v;
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 5) == 0);
            cyc(r, v, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/led_counter_sequencer.md
Name: led_counter_sequencer

Overview:
- Controls the free-running LED binary counter: owns the count register and drives the LED bus, and adds a command port for stop/run-up/run-down/load.
- An internal prescaler turns the fast system clock into visible count steps.
- Sits between the board-level command source (button decoder or host register) and the LED pins.
- Replaces the plain always-incrementing counter at the top level.

Parameters:
- CNT_WIDTH, 8, width of count and LED bus.
- PRESCALE, 25000000, clk cycles per count step while running. Must be >= 1; PRESCALE=1 steps every cycle.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_op  input  2  0=STOP, 1=RUN_UP, 2=RUN_DOWN, 3=LOAD.
- cmd_data  input  CNT_WIDTH  load value; used only for LOAD.
- led  output  CNT_WIDTH  current count, registered.
- busy  output  1  high when state is not IDLE.
- wrap  output  1  one-cycle pulse, registered with led, on a terminal event.

Behaviour:
- Reset (rst high at an edge):
  - state=IDLE, led=0, wrap=0, busy=0, cmd_ready=1.
  - Prescaler=0 and saved run state=IDLE.
  - Reset overrides any command or tick in the same cycle, including mid-LOAD.
- States: IDLE, UP, DOWN, LOAD.
- Handshake:
  - A command is accepted at an edge when cmd_valid && cmd_ready.
  - cmd_ready=1 in IDLE/UP/DOWN; cmd_ready=0 in LOAD.
  - cmd_op and cmd_data are sampled only at acceptance.
- Transitions on accept:
  - STOP goes to IDLE; led is held.
  - RUN_UP goes to UP; RUN_DOWN goes to DOWN.
  - LOAD saves the current state as the return state (IDLE/UP/DOWN), latches cmd_data and goes to LOAD.
- LOAD:
  - Lasts exactly one cycle.
  - At the next edge led=latched data and state=return state.
  - wrap stays 0.
- Prescaler:
  - Counts 0..PRESCALE-1 only in UP/DOWN.
  - Forced to 0 in IDLE, in LOAD, and at every accepted command, including a repeat of the current direction.
  - tick = (prescaler==PRESCALE-1) in UP/DOWN. At a tick edge the prescaler returns to 0 and led steps by 1.
- Latency:
  - The first step occurs PRESCALE cycles after the accept edge; each later step follows PRESCALE cycles after the previous one.
- Simultaneous command and tick: the command wins, no step occurs that edge, and the prescaler clears.
- Arithmetic: modulo 2^CNT_WIDTH. UP at all-ones gives 0; DOWN at 0 gives all-ones.
- wrap:
  - High for the one cycle after an edge where a step crossed a terminal value (all-ones to 0 going up, 0 to all-ones going down).
  - Otherwise 0.
- busy is a registered decode of state.

Optional Feature:
- Macro: LED_COUNTER_SEQUENCER_BOUNCE_EN.
- Defined:
  - A tick in UP with led=all-ones moves to DOWN and sets led=all-ones-1.
  - A tick in DOWN with led=0 moves to UP and sets led=1.
  - wrap pulses on each reversal.
  - A non-tick command in the same cycle still wins.
- Undefined: modulo wrap as above; the direction never changes without a command.

Decomposition:
- Package led_counter_pkg holds:
  - cmd_op localparams OP_STOP/OP_RUN_UP/OP_RUN_DOWN/OP_LOAD;
  - the state encoding (2-bit) ST_IDLE/ST_UP/ST_DOWN/ST_LOAD.
- One sub-module, tick_prescaler:
  - parameter PRESCALE; inputs clk, rst, run, clear; output tick;
  - counter width max(1, clog2(PRESCALE)).
- The FSM, count register and wrap logic stay in the top module.

Test Plan (PRESCALE=4, CNT_WIDTH=8):
- Reset, no commands for 20 cycles -> led=0, busy=0, wrap=0, cmd_ready=1 throughout.
- RUN_UP accepted at edge E -> led=1 at E+4, 2 at E+8, 3 at E+12. STOP at E+13 -> led held at 3 for 20 cycles, busy=0.
- LOAD 0xFE while UP -> cmd_ready=0 for one cycle, then led=0xFE with state UP. Then led=0xFF, then 0x00 with wrap high exactly one cycle.
- RUN_DOWN from led=0 -> after 4 cycles led=0xFF, wrap pulse.
  - With BOUNCE_EN: UP from 0xFE steps to 0xFF, then to 0xFE with direction DOWN and a wrap pulse.
- RUN_UP re-issued on the exact tick edge -> no step that edge; the next step is 4 cycles later.
- rst asserted during the LOAD cycle -> led=0, state IDLE, and the load value is never applied.
